pid_sample_sequencer: RTL and testbench

//  Sequences one servo PID sample: periodic tick -> ADC handshake -> error-register load -> pipeline wait -> integrator update -> output valid.

---
 rtl/servo_ctrl_pkg.sv | 19 +
 rtl/sample_timer.sv | 29 ++
 rtl/pid_sample_sequencer.sv | 113 +++++++++++
 tb/tb_pid_sample_sequencer.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/servo_ctrl_pkg.sv
// servo_ctrl_pkg: shared sequencer state encoding and default sizing for the servo PID sample path.
package servo_ctrl_pkg;

  localparam int CNT_W_DEF       = 20;
  localparam int TO_W_DEF        = 10;
  localparam int PIPE_LAT_DEF    = 2;
  localparam int ADC_TIMEOUT_DEF = 1000;
  localparam int MIN_PERIOD_DEF  = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADC_REQ,
    S_LOAD,
    S_WAIT,
    S_UPDATE,
    S_PUBLISH
  } state_e;

endpackage

// File: rtl/sample_timer.sv
// sample_timer: periodic sample tick from a reloading down-counter with a minimum-period clamp.
module sample_timer
  import servo_ctrl_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int MIN_PERIOD = MIN_PERIOD_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [CNT_W-1:0] period,
  output logic             tick
);

  logic [CNT_W-1:0] cnt_q, cnt_d, eff_period;

  // period is only sampled at reload, so a change lands on the next sample boundary
  always_comb begin
    eff_period = (period < CNT_W'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD) : period;
    tick       = enable && (cnt_q == '0);
    cnt_d      = !enable ? '0 : tick ? eff_period - CNT_W'(1) : cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pid_sample_sequencer.sv
// pid_sample_sequencer: per-sample control FSM (tick -> ADC -> error load -> pipeline wait -> integrator update -> publish)
// with ADC timeout, anti-windup gating of en_reg and sticky overrun/adc_fault flags.
module pid_sample_sequencer
  import servo_ctrl_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int PIPE_LAT    = PIPE_LAT_DEF,
  parameter int TO_W        = TO_W_DEF,
  parameter int ADC_TIMEOUT = ADC_TIMEOUT_DEF,
  parameter int MIN_PERIOD  = MIN_PERIOD_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [CNT_W-1:0] period,
  input  logic             adc_done,
  input  logic             sat_flag,
  input  logic             clr_flags,
  output logic             adc_start,
  output logic             en_error,
  output logic             en_reg,
  output logic             u_valid,
  output logic             busy,
  output logic             overrun,
  output logic             adc_fault
);

  localparam int WT_W = (PIPE_LAT > 0) ? $clog2(PIPE_LAT + 1) : 1;

  state_e          state_q, state_d;
  logic [TO_W-1:0] to_q, to_d;
  logic [WT_W-1:0] wait_q, wait_d;
  logic            overrun_q, overrun_d, fault_q, fault_d;
  logic            tick, timeout;

  sample_timer #(
    .CNT_W      (CNT_W),
    .MIN_PERIOD (MIN_PERIOD)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .period (period),
    .tick   (tick)
  );

  always_comb begin
    state_d = state_q;
    to_d    = to_q;
    wait_d  = wait_q;
    timeout = 1'b0;
    case (state_q)
      S_IDLE: begin
        to_d = '0;
        if (tick) begin
          state_d = S_ADC_REQ;
          to_d    = TO_W'(1);
        end
      end
      // to_q counts ADC_REQ cycles from 1, so adc_start spans exactly ADC_TIMEOUT cycles on a timeout
      S_ADC_REQ: begin
        if (adc_done) state_d = S_LOAD;
        else if (to_q >= TO_W'(ADC_TIMEOUT)) begin
          timeout = 1'b1;
          state_d = S_IDLE;
        end else to_d = to_q + TO_W'(1);
      end
      S_LOAD: begin
        wait_d  = WT_W'(PIPE_LAT);
        state_d = (PIPE_LAT == 0) ? S_UPDATE : S_WAIT;
      end
      S_WAIT: begin
        if (wait_q <= WT_W'(1)) state_d = S_UPDATE;
        else wait_d = wait_q - WT_W'(1);
      end
      S_UPDATE:  state_d = S_PUBLISH;
      S_PUBLISH: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (!enable) begin
      state_d = S_IDLE;
      timeout = 1'b0;
    end
    overrun_d = (tick && state_q != S_IDLE) || (overrun_q && !clr_flags);
    fault_d   = timeout || (fault_q && !clr_flags);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      to_q      <= '0;
      wait_q    <= '0;
      overrun_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      to_q      <= to_d;
      wait_q    <= wait_d;
      overrun_q <= overrun_d;
      fault_q   <= fault_d;
    end
  end

  // dropping enable silences every strobe in the same cycle, before the FSM returns to IDLE
  assign adc_start = enable && state_q == S_ADC_REQ;
  assign en_error  = enable && state_q == S_LOAD;
  assign en_reg    = enable && state_q == S_UPDATE && !sat_flag;
  assign u_valid   = enable && state_q == S_PUBLISH;
  assign busy      = enable && state_q != S_IDLE;
  assign overrun   = overrun_q;
  assign adc_fault = fault_q;

endmodule

// File: tb/tb_pid_sample_sequencer.sv
// tb_pid_sample_sequencer: scenario tasks plus randomized traffic against a timestamp-based model
// that predicts every output from tick times and the adc_done arrival time of each sample.
module tb_pid_sample_sequencer;

  localparam int CNT_W = 20;
  localparam int PL    = 2;
  localparam int TO    = 1000;
  localparam int MINP  = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             enable = 1'b0;
  logic [CNT_W-1:0] period = '0;
  logic             adc_done = 1'b0;
  logic             sat_flag = 1'b0;
  logic             clr_flags = 1'b0;
  logic             adc_start, en_error, en_reg, u_valid, busy, overrun, adc_fault;
  logic [6:0]       obs_v, exp_v;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // model: a sample is "in flight" from req_start; done_at is the cycle adc_done was accepted (-1 while waiting)
  int next_tick = 0;
  int req_start = 0;
  int done_at   = -1;
  bit in_seq    = 1'b0;
  bit m_ovr     = 1'b0;
  bit m_flt     = 1'b0;

  always #5 clk = ~clk;

  pid_sample_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .period    (period),
    .adc_done  (adc_done),
    .sat_flag  (sat_flag),
    .clr_flags (clr_flags),
    .adc_start (adc_start),
    .en_error  (en_error),
    .en_reg    (en_reg),
    .u_valid   (u_valid),
    .busy      (busy),
    .overrun   (overrun),
    .adc_fault (adc_fault)
  );

  assign obs_v = {adc_start, en_error, en_reg, u_valid, busy, overrun, adc_fault};

  task automatic half();
    bit live;
    @(negedge clk);
    live  = in_seq && enable;
    exp_v = {live && done_at < 0,
             live && done_at >= 0 && cyc == done_at + 1,
             live && done_at >= 0 && cyc == done_at + 2 + PL && !sat_flag,
             live && done_at >= 0 && cyc == done_at + 3 + PL,
             live, m_ovr, m_flt};
  endtask

  task automatic adv();
    bit tk, set_o, set_f;
    tk    = enable && cyc == next_tick;
    set_o = 1'b0;
    set_f = 1'b0;
    if (!enable) begin
      in_seq    = 1'b0;
      next_tick = cyc + 1;
    end else begin
      if (tk) next_tick = cyc + ((period < MINP) ? MINP : int'(period));
      if (in_seq) begin
        set_o = tk;
        if (done_at < 0) begin
          if (adc_done) done_at = cyc;
          else if (cyc - req_start + 1 == TO) begin
            set_f  = 1'b1;
            in_seq = 1'b0;
          end
        end else if (cyc == done_at + 3 + PL) in_seq = 1'b0;
      end else if (tk) begin
        in_seq    = 1'b1;
        req_start = cyc + 1;
        done_at   = -1;
      end
    end
    m_ovr = set_o || (m_ovr && !clr_flags);
    m_flt = set_f || (m_flt && !clr_flags);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst       = 1'b1;
    in_seq    = 1'b0;
    done_at   = -1;
    m_ovr     = 1'b0;
    m_flt     = 1'b0;
    next_tick = cyc;
  endtask

  task automatic test_reset();
    #1;
    total++;
    if (obs_v !== 7'b0) begin
      bad++;
      $display("FAIL reset_async got=%b exp=%b", obs_v, 7'b0);
    end
    enable = 1'b1;
    period = CNT_W'(20);
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (obs_v !== 7'b0) begin
      bad++;
      $display("FAIL reset_hold got=%b exp=%b", obs_v, 7'b0);
    end
    enable = 1'b0;
  endtask

  task automatic test_nominal();
    int s, e, u1, u2;
    s = -1; e = -1; u1 = -1; u2 = -1;
    enable = 1'b1; period = CNT_W'(20); adc_done = 1'b1; sat_flag = 1'b0; clr_flags = 1'b0;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      half();
      total++;
      if (obs_v !== exp_v) begin
        bad++;
        $display("FAIL nominal cyc=%0d got=%b exp=%b", cyc, obs_v, exp_v);
      end
      if (adc_start && s < 0) s = i;
      if (en_error && e < 0) e = i;
      if (u_valid) begin
        if (u1 < 0) u1 = i;
        else if (u2 < 0) u2 = i;
      end
      adv();
    end
    total++;
    if (s != 1 || e != 2 || u1 != 6) begin
      bad++;
      $display("FAIL nominal_latency got start=%0d err=%0d uv=%0d exp start=1 err=2 uv=6", s, e, u1);
    end
    total++;
    if (u2 - u1 != 20) begin
      bad++;
      $display("FAIL nominal_period got=%0d exp=20", u2 - u1);
    end
  endtask

  task automatic test_adc_delay();
    int n_start, s, u;
    n_start = 0; s = -1; u = -1;
    enable = 1'b1; period = CNT_W'(40); sat_flag = 1'b0; clr_flags = 1'b0; adc_done = 1'b0;
    do_reset();
    for (int i = 0; i < 30; i++) begin
      adc_done = in_seq && done_at < 0 && (cyc - req_start == 6);
      half();
      total++;
      if (obs_v !== exp_v) begin
        bad++;
        $display("FAIL adc_delay cyc=%0d got=%b exp=%b", cyc, obs_v, exp_v);
      end
      if (adc_start) begin
        n_start++;
        if (s < 0) s = i;
      end
      if (u_valid && u < 0) u = i;
      adv();
    end
    adc_done = 1'b0;
    total++;
    if (n_start != 7 || u - s != 11) begin
      bad++;
      $display("FAIL adc_delay_span got start_cycles=%0d uv_after_start=%0d exp 7 11", n_start, u - s);
    end
  endtask

  task automatic test_timeout();
    int n_start;
    n_start = 0;
    enable = 1'b1; period = CNT_W'(1500); adc_done = 1'b0; sat_flag = 1'b0; clr_flags = 1'b0;
    do_reset();
    for (int i = 0; i < 1005; i++) begin
      half();
      total++;
      if (obs_v !== exp_v) begin
        bad++;
        $display("FAIL timeout cyc=%0d got=%b exp=%b", cyc, obs_v, exp_v);
      end
      if (adc_start) n_start++;
      adv();
    end
    total++;
    if (n_start != TO || adc_fault !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL timeout_fault got start_cycles=%0d fault=%b busy=%b exp %0d 1 0", n_start, adc_fault, busy, TO);
    end
    clr_flags = 1'b1;
    half();
    adv();
    clr_flags = 1'b0;
    half();
    total++;
    if (adc_fault !== 1'b0 || obs_v !== exp_v) begin
      bad++;
      $display("FAIL timeout_clear got fault=%b vec=%b exp fault=0 vec=%b", adc_fault, obs_v, exp_v);
    end
    adv();
  endtask

  task automatic test_saturation();
    int n_reg, n_uv;
    enable = 1'b1; period = CNT_W'(20); adc_done = 1'b1; clr_flags = 1'b0;
    do_reset();
    for (int p = 0; p < 2; p++) begin
      n_reg = 0; n_uv = 0;
      sat_flag = (p == 0);
      for (int i = 0; i < 20; i++) begin
        half();
        total++;
        if (obs_v !== exp_v) begin
          bad++;
          $display("FAIL saturation cyc=%0d got=%b exp=%b", cyc, obs_v, exp_v);
        end
        n_reg += int'(en_reg);
        n_uv  += int'(u_valid);
        adv();
      end
      total++;
      if (n_reg != p || n_uv != 1) begin
        bad++;
        $display("FAIL saturation_pulses sat=%0d got en_reg=%0d uv=%0d exp %0d 1", 1 - p, n_reg, n_uv, p);
      end
    end
    sat_flag = 1'b0;
  endtask

  task automatic test_min_period_overrun();
    int n_err;
    n_err = 0;
    enable = 1'b1; period = CNT_W'(5); sat_flag = 1'b0; clr_flags = 1'b0; adc_done = 1'b0;
    do_reset();
    for (int i = 0; i < 100; i++) begin
      adc_done = in_seq && done_at < 0 && (cyc - req_start == 29);
      half();
      total++;
      if (obs_v !== exp_v) begin
        bad++;
        $display("FAIL overrun cyc=%0d got=%b exp=%b", cyc, obs_v, exp_v);
      end
      n_err += int'(en_error);
      adv();
    end
    adc_done = 1'b0;
    total++;
    if (overrun !== 1'b1 || n_err != 2) begin
      bad++;
      $display("FAIL overrun_flag got ovr=%b en_error=%0d exp 1 2", overrun, n_err);
    end
  endtask

  task automatic test_abort();
    int n_bad;
    n_bad = 0;
    enable = 1'b1; period = CNT_W'(20); adc_done = 1'b1; sat_flag = 1'b0; clr_flags = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      half();
      total++;
      if (obs_v !== exp_v) begin
        bad++;
        $display("FAIL abort_pre cyc=%0d got=%b exp=%b", cyc, obs_v, exp_v);
      end
      adv();
    end
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL abort_in_wait got busy=%b exp 1", busy);
    end
    rst = 1'b0;
    #1;
    total++;
    if (obs_v !== 7'b0) begin
      bad++;
      $display("FAIL abort_rst got=%b exp=%b", obs_v, 7'b0);
    end
    adc_done = 1'b0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      half();
      adv();
    end
    enable = 1'b0;
    #1;
    total++;
    if (obs_v !== 7'b0) begin
      bad++;
      $display("FAIL abort_disable got=%b exp=%b", obs_v, 7'b0);
    end
    adc_done = 1'b1;
    for (int i = 0; i < 10; i++) begin
      half();
      total++;
      if (obs_v !== exp_v) begin
        bad++;
        $display("FAIL abort_post cyc=%0d got=%b exp=%b", cyc, obs_v, exp_v);
      end
      n_bad += int'(en_reg) + int'(u_valid);
      adv();
    end
    total++;
    if (n_bad != 0) begin
      bad++;
      $display("FAIL abort_no_strobes got=%0d exp=0", n_bad);
    end
  endtask

  task automatic test_random();
    enable = 1'b1; period = CNT_W'(24);
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      enable    = ($urandom_range(0, 199) != 0);
      adc_done  = ($urandom_range(0, 3) == 0);
      sat_flag  = $urandom_range(0, 1) == 1;
      clr_flags = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 99) == 0) period = CNT_W'($urandom_range(0, 40));
      half();
      total++;
      if (obs_v !== exp_v) begin
        bad++;
        $display("FAIL random cyc=%0d got=%b exp=%b", cyc, obs_v, exp_v);
      end
      adv();
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_adc_delay();
    test_timeout();
    test_saturation();
    test_min_period_overrun();
    test_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
